// File: rtl/fprint_comparator.sv
// Fingerprint comparator: reads each core's CRC fingerprints at its tail pointer, votes (TMR)
// or compares (DMR), advances the tails, rewinds the task and reports one result per request.
module fprint_comparator #(
   parameter int KEY_WIDTH   = 4,
   parameter int ADDR_WIDTH  = 10,
   parameter int CRC_WIDTH   = 32,
   parameter int COUNT_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [KEY_WIDTH-1:0]   req_task_id,
   input  logic [COUNT_WIDTH-1:0] req_count,
   input  logic                   req_tmr,
   output logic [KEY_WIDTH-1:0]   comparator_task_id,
   input  logic [ADDR_WIDTH-1:0]  comp_tail_pointer_0,
   input  logic [ADDR_WIDTH-1:0]  comp_tail_pointer_1,
   input  logic [ADDR_WIDTH-1:0]  comp_tail_pointer_2,
   output logic                   comparator_inc_tail_pointer,
   input  logic                   comp_inc_tail_pointer_ack,
   output logic                   comp_reset_task,
   input  logic                   comp_reset_task_ack,
   output logic [ADDR_WIDTH-1:0]  ram_addr,
   output logic [1:0]             ram_core_sel,
   input  logic [CRC_WIDTH-1:0]   ram_rdata,
   output logic                   result_valid,
   output logic [KEY_WIDTH-1:0]   result_task_id,
   output logic                   result_match,
   output logic [2:0]             result_fail_mask,
   output logic [COUNT_WIDTH-1:0] result_index
);

   typedef enum logic [3:0] {
      S_IDLE, S_SETTLE, S_RD0, S_RD1, S_RD2, S_CMP, S_INC, S_RST, S_DONE
   } state_t;

   state_t                 state, state_nxt;
   logic                   rd_phase;
   logic [COUNT_WIDTH-1:0] count_r, index_r, index_inc;
   logic                   tmr_r, match_r;
   logic [2:0]             mask_r, cmp_mask;
   logic [CRC_WIDTH-1:0]   crc0, crc1, crc2;
   logic                   in_read, e01, e02, e12;

   assign in_read   = (state == S_RD0) || (state == S_RD1) || (state == S_RD2);
   assign index_inc = index_r + COUNT_WIDTH'(1);
   assign e01       = (crc0 == crc1);
   assign e02       = (crc0 == crc2);
   assign e12       = (crc1 == crc2);

   // Handshake requests are decoded straight from the state so an async reset drops them at once.
   assign req_ready                   = (state == S_IDLE);
   assign comparator_inc_tail_pointer = (state == S_INC);
   assign comp_reset_task             = (state == S_RST);
   assign result_valid                = (state == S_DONE);

   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      cmp_mask = 3'b000;
      if (tmr_r) begin
         if (e01 && e02)  cmp_mask = 3'b000;
         else if (e01)    cmp_mask = 3'b100;
         else if (e02)    cmp_mask = 3'b010;
         else if (e12)    cmp_mask = 3'b001;
         else             cmp_mask = 3'b111;
      end else if (!e01) begin
         cmp_mask = 3'b011;
      end
   end

   always_comb begin
      ram_addr     = '0;
      ram_core_sel = 2'd0;
      if (!rd_phase) begin
         unique case (state)
            S_RD0:   begin ram_addr = comp_tail_pointer_0; ram_core_sel = 2'd0; end
            S_RD1:   begin ram_addr = comp_tail_pointer_1; ram_core_sel = 2'd1; end
            S_RD2:   begin ram_addr = comp_tail_pointer_2; ram_core_sel = 2'd2; end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:   if (req_valid) state_nxt = (req_count == '0) ? S_RST : S_SETTLE;
         S_SETTLE: state_nxt = S_RD0;
         S_RD0:    if (rd_phase) state_nxt = S_RD1;
         S_RD1:    if (rd_phase) state_nxt = tmr_r ? S_RD2 : S_CMP;
         S_RD2:    if (rd_phase) state_nxt = S_CMP;
         S_CMP:    state_nxt = (cmp_mask == 3'b000) ? S_INC : S_RST;
         S_INC:    if (comp_inc_tail_pointer_ack)
                      state_nxt = (index_inc == count_r) ? S_RST : S_SETTLE;
         S_RST:    if (comp_reset_task_ack) state_nxt = S_DONE;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_phase           <= 1'b0;
         comparator_task_id <= '0;
         count_r            <= '0;
         index_r            <= '0;
         tmr_r              <= 1'b0;
         match_r            <= 1'b0;
         mask_r             <= 3'b000;
         crc0               <= '0;
         crc1               <= '0;
         crc2               <= '0;
         result_task_id     <= '0;
         result_match       <= 1'b0;
         result_fail_mask   <= 3'b000;
         result_index       <= '0;
      end else begin
         rd_phase <= in_read ? ~rd_phase : 1'b0;
         unique case (state)
            S_IDLE: if (req_valid) begin
               comparator_task_id <= req_task_id;
               count_r            <= req_count;
               tmr_r              <= req_tmr;
               index_r            <= '0;
               match_r            <= 1'b1;
               mask_r             <= 3'b000;
            end
            S_RD0: if (rd_phase) crc0 <= ram_rdata;
            S_RD1: if (rd_phase) crc1 <= ram_rdata;
            S_RD2: if (rd_phase) crc2 <= ram_rdata;
            S_CMP: if (cmp_mask != 3'b000) begin
               match_r <= 1'b0;
               mask_r  <= cmp_mask;
            end
            S_INC: if (comp_inc_tail_pointer_ack) index_r <= index_inc;
            S_RST: if (comp_reset_task_ack) begin
               result_task_id   <= comparator_task_id;
               result_match     <= match_r;
               result_fail_mask <= mask_r;
               result_index     <= match_r ? '0 : index_r;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/fprint_comparator.md
Name: fprint_comparator

Overview:
- Consumer stage downstream of the fingerprint pointer register block.
- On a compare request for one task, it reads each core's stored CRC fingerprints from the fingerprint RAM at that core's tail pointer.
- It compares them by majority vote (TMR) or equality (DMR), advances the tail pointers through the increment handshake, and rewinds the task through the reset-task handshake.
- It reports one pass/fail result per request to the monitor/CSR side.

Parameters:
- KEY_WIDTH, 4, task id width (16 tasks).
- ADDR_WIDTH, 10, fingerprint RAM address width (matches pointer width).
- CRC_WIDTH, 32, fingerprint width.
- COUNT_WIDTH, 8, width of the fingerprint count per request.

Ports:
- clk  in  1  clock
- reset  in  1  reset; asynchronous, active-high
- req_valid  in  1  compare request
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid & req_ready
- req_task_id  in  KEY_WIDTH  task to compare
- req_count  in  COUNT_WIDTH  number of fingerprints per core to compare
- req_tmr  in  1  1 = cores 0,1,2; 0 = cores 0,1 only
- comparator_task_id  out  KEY_WIDTH  task id latched at accept
- comp_tail_pointer_0/1/2  in  ADDR_WIDTH  per-core tail pointers for comparator_task_id
- comparator_inc_tail_pointer  out  1  tail increment request
- comp_inc_tail_pointer_ack  in  1  one-cycle ack
- comp_reset_task  out  1  rewind head/tail request
- comp_reset_task_ack  in  1  one-cycle ack
- ram_addr  out  ADDR_WIDTH  fingerprint RAM read address
- ram_core_sel  out  2  RAM bank (core) select
- ram_rdata  in  CRC_WIDTH  read data, valid exactly 1 cycle after address
- result_valid  out  1  one-cycle result pulse
- result_task_id  out  KEY_WIDTH  task of the result
- result_match  out  1  1 = all compared fingerprints agreed
- result_fail_mask  out  3  disagreeing core(s)
- result_index  out  COUNT_WIDTH  index of the first mismatch; 0 when matched

Behaviour:
- Reset: state IDLE; all outputs 0 except req_ready = 1; internal count, index and captured CRCs cleared. Reset mid-operation abandons the request without issuing any further handshakes.
- States: IDLE, SETTLE, RD0, RD1, RD2, CMP, INC, RST, DONE.
- IDLE:
  - On accept, latch task id, count and tmr; clear the index.
  - If count == 0, go to RST; otherwise go to SETTLE.
- SETTLE: one cycle, so the registered tail pointers reflect comparator_task_id.
- RDk (k = 0, 1, 2):
  - Two cycles each. Cycle 1 drives ram_addr = comp_tail_pointer_k and ram_core_sel = k; cycle 2 captures ram_rdata into crc_k.
  - RD0 → RD1; RD1 → RD2 if tmr, else CMP; RD2 → CMP.
- CMP (one cycle):
  - DMR: crc0 == crc1 is a match; otherwise mask = 3'b011.
  - TMR: all three equal is a match. If exactly one differs, mask flags that core (e.g. crc0 == crc1 != crc2 → 3'b100). All three different → 3'b111.
  - On mismatch: latch mask and index, set match = 0, go to RST (stop at first mismatch).
  - On match: go to INC.
- INC:
  - Hold comparator_inc_tail_pointer high until comp_inc_tail_pointer_ack is sampled high, then deassert on the next cycle.
  - Then increment index. If index == count, go to RST; else go to SETTLE.
- RST:
  - Hold comp_reset_task high until comp_reset_task_ack is sampled high, then go to DONE.
  - The task is always rewound at completion or failure.
- DONE:
  - result_valid = 1 for one cycle; result_* stable from this cycle until the next DONE.
  - Then go to IDLE.
- Acks arriving while not requesting are ignored. Inc and reset requests are never high simultaneously.
- Index arithmetic is unsigned COUNT_WIDTH, no wrap: count max is 2^COUNT_WIDTH − 1. Tail wrap-around is owned by the upstream register block.
- req_valid while busy is ignored (not queued).

Test Plan:
- Bench ack model: ack pulses one cycle, 2 cycles after the request rises. Bench RAM: 1-cycle latency.
- Scenario 1: TMR, task 3, count 2, all CRCs 0xDEADBEEF → 2 inc handshakes, 1 reset handshake; result_valid with task 3, match = 1, mask = 0, index = 0.
- Scenario 2: DMR, task 5, count 3, core 1 fingerprint #1 = 0x1 vs 0x2 → exactly 1 inc; core 2 never addressed; then reset; result match = 0, mask = 3'b011, index = 1.
- Scenario 3: TMR, count 1, crc0 = crc2 = 0xA, crc1 = 0xB → mask = 3'b010; no inc; reset issued. Then repeat with all three different → mask = 3'b111.
- Scenario 4: count = 0 → no RAM reads, no inc, one reset handshake; result match = 1. req_valid pulsed while busy → no second result.
- Scenario 5: assert reset during INC with the inc request high → request drops asynchronously; req_ready = 1 next cycle; no result_valid. A new request then completes normally.
- Scenario 6: tail pointers 1023 → 0 across an inc (upstream wrap) → ram_addr follows: 1023, then 0.
